cpt_chain_ctrl: RTL and testbench
=================================

Name: cpt_chain_ctrl

Overview:
Sequencing controller for a chain of modulo-N digit counters, forming a multi-digit stopwatch/countdown timer. A prescaler turns Clk into count ticks. An FSM handles start/stop/clear/load commands. Digit carries and borrows ripple through the chain. The block sits between push-button command logic and the 7-segment display path, which consumes Q.

Parameters:
DIGIT_WIDTH, 4, bits per digit
DIGIT_MOD, 10, modulo of each digit (2..2^DIGIT_WIDTH)
NB_DIGITS, 4, number of chained digits
PRESCALE, 1000, Clk cycles per count tick (>=1)
PRESC_WIDTH, 10, prescaler width (2^PRESC_WIDTH >= PRESCALE)

Ports:
Clk  in  1  clock, rising edge active
Reset  in  1  synchronous reset, active-high
Start  in  1  start/resume command (level, sampled each cycle)
Stop  in  1  pause command
Clear  in  1  clear command
Load  in  1  load LoadVal into the chain
Down  in  1  direction for the next run from IDLE (1 = count down)
LoadVal  in  NB_DIGITS*DIGIT_WIDTH  packed digits to load, digit0 in LSBs
Q  out  NB_DIGITS*DIGIT_WIDTH  packed digit values, digit0 = least significant
Tick  out  1  one-cycle pulse, high during the first cycle a new Q is visible
CarryOut  out  1  one-cycle pulse coincident with Tick when the up-count wraps the whole chain
Running  out  1  high in RUN
Done  out  1  high in DONE

Behaviour:
- One clock (Clk). Reset is synchronous and active-high.
- Reset: state IDLE, Q=0, prescaler=0, latched direction=up, Tick=CarryOut=Running=Done=0.
- FSM states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Command priority, highest first: Clear > Load > Stop > Start.
- Clear, in any state: next state IDLE, Q=0, prescaler=0.
- Load, in IDLE/PAUSE/DONE: Q<=LoadVal, next state IDLE, prescaler=0.
  - Any loaded digit >= DIGIT_MOD is clamped to DIGIT_MOD-1.
  - Load is ignored in RUN.
- IDLE + Start:
  - Latch Down, clear prescaler, go to RUN.
  - Exception: if Down=1 and Q==0, go directly to DONE with no tick.
- PAUSE + Start: go to RUN. The prescaler value is retained; direction is not re-sampled.
- RUN + Stop: go to PAUSE. Prescaler and Q are frozen.
- DONE: Start and Stop are ignored. Exit only via Clear or Load. Q is held.
- Prescaler, in RUN only:
  - Increments each cycle.
  - At PRESCALE-1 it wraps to 0 and, on that same edge, the chain updates and Tick is registered high.
  - With PRESCALE=1, a tick occurs every RUN cycle.
  - First tick comes exactly PRESCALE cycles after entering RUN from IDLE.
- Up count:
  - digit0 increments.
  - digit i increments only if all lower digits equal DIGIT_MOD-1.
  - A digit at DIGIT_MOD-1 that increments wraps to 0.
  - All digits at DIGIT_MOD-1: chain wraps to all-0, CarryOut=1 with Tick, stays in RUN.
- Down count:
  - digit0 decrements.
  - digit i decrements only if all lower digits equal 0.
  - A digit at 0 that decrements wraps to DIGIT_MOD-1.
  - On the tick that makes Q reach all-0: go to DONE, Done=1 from the next cycle. No underflow wrap occurs.
- Tick and CarryOut are never high outside the cycle following a prescaler wrap.
- Running mirrors state==RUN. Done mirrors state==DONE.
- A Stop on the same edge as the prescaler wrap: Stop wins, no tick, prescaler keeps PRESCALE-1 and ticks on the first RUN cycle after resume.
- Reset or Clear mid-run aborts any pending tick; no Tick/CarryOut in the following cycle.

Test Plan:
- Reset, then Start with Down=0 (NB_DIGITS=2, MOD=10, PRESCALE=4) -> Tick every 4 cycles; Q=0x01,0x02,...,0x09,0x10; first Tick 4 cycles after Start.
- Load 0x98, Start up -> Q 0x99 then 0x00, CarryOut=1 together with Tick on the wrap, Running stays 1.
- Load 0x03, Start with Down=1 -> Q 0x02,0x01,0x00, Done=1 the cycle after Q=0x00; later Start/Stop ignored, Q held at 0x00.
- Run up; Stop after 2 prescaler cycles; hold 10 cycles; Start -> Q frozen while PAUSE; next Tick exactly 2 cycles after resume.
- Load 0xFA (digits out of range) -> Q=0x99 after clamping. Start+Clear asserted together in RUN -> IDLE, Q=0, no Tick.
- Down=1, Start with Q=0 -> DONE next cycle, Tick never asserted. Reset asserted mid-RUN -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/cpt_chain_ctrl.sv
// Stopwatch/countdown sequencer: prescaler, start/stop/clear/load FSM and a chained modulo-N digit counter.
// Latency: commands act on the next edge; Q, Tick and CarryOut update together on the prescaler wrap edge.
// Backpressure: none. Commands are levels sampled every cycle with priority Clear > Load > Stop > Start.
module cpt_chain_ctrl #(
    parameter int DIGIT_WIDTH = 4,
    parameter int DIGIT_MOD   = 10,
    parameter int NB_DIGITS   = 4,
    parameter int PRESCALE    = 1000,
    parameter int PRESC_WIDTH = 10
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             Start,
    input  logic                             Stop,
    input  logic                             Clear,
    input  logic                             Load,
    input  logic                             Down,
    input  logic [NB_DIGITS*DIGIT_WIDTH-1:0] LoadVal,
    output logic [NB_DIGITS*DIGIT_WIDTH-1:0] Q,
    output logic                             Tick,
    output logic                             CarryOut,
    output logic                             Running,
    output logic                             Done
);
    localparam int QW = NB_DIGITS * DIGIT_WIDTH;
    localparam logic [DIGIT_WIDTH-1:0] DMAX = DIGIT_WIDTH'(DIGIT_MOD - 1);
    localparam logic [PRESC_WIDTH-1:0] PMAX = PRESC_WIDTH'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                 state_q;
    logic [QW-1:0]          q_q;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic                   dir_q;
    logic                   tick_q;
    logic                   carry_q;

    logic [QW-1:0]          inc_d;
    logic [QW-1:0]          dec_d;
    logic [QW-1:0]          load_d;
    logic [DIGIT_WIDTH-1:0] digit;
    logic                   carry_c;
    logic                   borrow_c;
    logic                   presc_wrap;

    // Ripple carry/borrow: a digit moves only when every lower digit sits at its wrap value.
    always_comb begin
        inc_d    = q_q;
        dec_d    = q_q;
        load_d   = LoadVal;
        digit    = '0;
        carry_c  = 1'b1;
        borrow_c = 1'b1;
        for (int i = 0; i < NB_DIGITS; i++) begin
            digit = q_q[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            if (carry_c)
                inc_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = (digit == DMAX) ? '0 : digit + 1'b1;
            if (borrow_c)
                dec_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = (digit == '0) ? DMAX : digit - 1'b1;
            carry_c  = carry_c & (digit == DMAX);
            borrow_c = borrow_c & (digit == '0);
            if (LoadVal[i*DIGIT_WIDTH +: DIGIT_WIDTH] > DMAX)
                load_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = DMAX;
        end
    end

    assign presc_wrap = (presc_q == PMAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            if (Clear) begin
                state_q <= S_IDLE;
                q_q     <= '0;
                presc_q <= '0;
            end else if (Load && state_q != S_RUN) begin
                state_q <= S_IDLE;
                q_q     <= load_d;
                presc_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!Stop && Start) begin
                            if (Down && q_q == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                dir_q   <= Down;
                                presc_q <= '0;
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!Stop && Start)
                            state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (Stop) begin
                            state_q <= S_PAUSE;
                        end else if (dir_q && q_q == '0) begin
                            // Countdown reached zero on the previous tick: finish without wrapping.
                            state_q <= S_DONE;
                        end else if (presc_wrap) begin
                            presc_q <= '0;
                            tick_q  <= 1'b1;
                            q_q     <= dir_q ? dec_d : inc_d;
                            carry_q <= ~dir_q & carry_c;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Q        = q_q;
    assign Tick     = tick_q;
    assign CarryOut = carry_q;
    assign Running  = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_cpt_chain_ctrl.sv
// Directed bench for cpt_chain_ctrl with two BCD digits and a prescale of 4.
module tb_cpt_chain_ctrl;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic       Clk = 1'b0;
    logic       Reset, Start, Stop, Clear, Load, Down;
    logic [7:0] LoadVal;
    logic [7:0] Q;
    logic       Tick, CarryOut, Running, Done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       st, sp, cl, ld, dn;
        logic [7:0] lv;
        logic [7:0] q;
        logic       t, c, r, d;
    } vec_t;

    vec_t vecs[17];

    always #5 Clk = ~Clk;

    cpt_chain_ctrl #(
        .DIGIT_WIDTH(4), .DIGIT_MOD(10), .NB_DIGITS(2), .PRESCALE(4), .PRESC_WIDTH(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
        .Load(Load), .Down(Down), .LoadVal(LoadVal), .Q(Q), .Tick(Tick),
        .CarryOut(CarryOut), .Running(Running), .Done(Done)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] q,
                              input logic t, input logic c, input logic r, input logic d);
        chk({tag, " Q"},        Q,            q);
        chk({tag, " Tick"},     8'(Tick),     8'(t));
        chk({tag, " CarryOut"}, 8'(CarryOut), 8'(c));
        chk({tag, " Running"},  8'(Running),  8'(r));
        chk({tag, " Done"},     8'(Done),     8'(d));
    endtask

    task automatic step(input logic st, input logic sp, input logic cl, input logic ld,
                        input logic dn, input logic [7:0] lv);
        Start = st; Stop = sp; Clear = cl; Load = ld; Down = dn; LoadVal = lv;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        step(O, O, O, O, O, 8'h00);
    endtask

    initial begin
        Reset = 1'b1;
        Start = O; Stop = O; Clear = O; Load = O; Down = O; LoadVal = 8'h00;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        expect_out("reset", 8'h00, O, O, O, O);
        Reset = 1'b0;

        //          st sp cl ld dn  lv      q      t  c  r  d
        vecs[0]  = '{O, O, O, O, O, 8'h00, 8'h00, O, O, O, O};
        vecs[1]  = '{O, O, O, I, O, 8'hFA, 8'h99, O, O, O, O};
        vecs[2]  = '{O, O, O, I, O, 8'h98, 8'h98, O, O, O, O};
        vecs[3]  = '{I, O, O, O, O, 8'h00, 8'h98, O, O, I, O};
        vecs[4]  = '{O, O, O, O, O, 8'h00, 8'h98, O, O, I, O};
        vecs[5]  = '{O, O, O, O, O, 8'h00, 8'h98, O, O, I, O};
        vecs[6]  = '{O, O, O, O, O, 8'h00, 8'h98, O, O, I, O};
        vecs[7]  = '{O, O, O, O, O, 8'h00, 8'h99, I, O, I, O};
        vecs[8]  = '{O, O, O, O, O, 8'h00, 8'h99, O, O, I, O};
        vecs[9]  = '{O, O, O, O, O, 8'h00, 8'h99, O, O, I, O};
        vecs[10] = '{O, O, O, O, O, 8'h00, 8'h99, O, O, I, O};
        vecs[11] = '{O, O, O, O, O, 8'h00, 8'h00, I, I, I, O};
        vecs[12] = '{O, O, O, O, O, 8'h00, 8'h00, O, O, I, O};
        vecs[13] = '{O, O, O, O, O, 8'h00, 8'h00, O, O, I, O};
        vecs[14] = '{O, O, O, O, O, 8'h00, 8'h00, O, O, I, O};
        vecs[15] = '{I, O, I, O, O, 8'h00, 8'h00, O, O, O, O};
        vecs[16] = '{O, O, O, O, O, 8'h00, 8'h00, O, O, O, O};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].ld, vecs[i].dn, vecs[i].lv);
            expect_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].t, vecs[i].c, vecs[i].r, vecs[i].d);
        end

        // Up count from zero: a tick exactly every 4 cycles, BCD roll from 09 to 10.
        step(I, O, O, O, O, 8'h00);
        expect_out("up start", 8'h00, O, O, I, O);
        for (int k = 1; k <= 10; k++) begin
            for (int j = 0; j < 3; j++) begin
                idle();
                chk($sformatf("up k%0d quiet%0d Tick", k, j), 8'(Tick), 8'h00);
            end
            idle();
            expect_out($sformatf("up k%0d", k), (k == 10) ? 8'h10 : 8'(k), I, O, I, O);
        end

        // Countdown from 03 into DONE; Done lags the zero tick by one cycle.
        step(O, O, I, O, O, 8'h00);
        step(O, O, O, I, O, 8'h03);
        step(I, O, O, O, I, 8'h00);
        expect_out("dn start", 8'h03, O, O, I, O);
        for (int k = 2; k >= 0; k--) begin
            for (int j = 0; j < 3; j++) begin
                idle();
                chk($sformatf("dn %0d quiet%0d Tick", k, j), 8'(Tick), 8'h00);
            end
            idle();
            expect_out($sformatf("dn %0d", k), 8'(k), I, O, I, O);
        end
        idle();
        expect_out("dn done", 8'h00, O, O, O, I);
        step(I, O, O, O, O, 8'h00);
        expect_out("done start", 8'h00, O, O, O, I);
        step(O, I, O, O, O, 8'h00);
        expect_out("done stop", 8'h00, O, O, O, I);
        idle();
        idle();
        expect_out("done hold", 8'h00, O, O, O, I);

        // Pause and resume, Load ignored while running, Stop coinciding with the wrap.
        step(O, O, I, O, O, 8'h00);
        step(I, O, O, O, O, 8'h00);
        step(O, O, O, I, O, 8'h55);
        expect_out("run load ignored", 8'h00, O, O, I, O);
        idle();
        step(O, I, O, O, O, 8'h00);
        expect_out("pause", 8'h00, O, O, O, O);
        for (int j = 0; j < 10; j++) begin
            idle();
            expect_out($sformatf("pause hold%0d", j), 8'h00, O, O, O, O);
        end
        step(I, O, O, O, O, 8'h00);
        expect_out("resume", 8'h00, O, O, I, O);
        idle();
        expect_out("resume +1", 8'h00, O, O, I, O);
        idle();
        expect_out("resume +2", 8'h01, I, O, I, O);
        idle();
        idle();
        idle();
        step(O, I, O, O, O, 8'h00);
        expect_out("stop on wrap", 8'h01, O, O, O, O);
        step(I, O, O, O, O, 8'h00);
        expect_out("wrap resume", 8'h01, O, O, I, O);
        idle();
        expect_out("wrap resume tick", 8'h02, I, O, I, O);

        // Countdown requested with Q already zero.
        step(O, O, I, O, O, 8'h00);
        step(I, O, O, O, I, 8'h00);
        expect_out("dn zero", 8'h00, O, O, O, I);
        for (int j = 0; j < 3; j++) begin
            idle();
            expect_out($sformatf("dn zero hold%0d", j), 8'h00, O, O, O, I);
        end

        // Reset on the edge that would have ticked.
        step(O, O, I, O, O, 8'h00);
        step(O, O, O, I, O, 8'h05);
        step(I, O, O, O, O, 8'h00);
        idle();
        idle();
        idle();
        Reset = 1'b1;
        idle();
        expect_out("mid reset", 8'h00, O, O, O, O);
        Reset = 1'b0;
        idle();
        expect_out("after reset", 8'h00, O, O, O, O);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
